// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU operand/result and response bundle of alu_cmd_sequencer.
// slave = sequencer view, master = environment view; ALU_STATS_EN adds the counters.
interface alu_cmd_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [1:0]       cmd_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_select;
   logic [WIDTH-1:0] alu_out;
   logic             alu_zero;
   logic             alu_carry;
   logic             alu_sign;
   logic             alu_parity;
   logic             alu_overflow;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_out;
   logic [4:0]       rsp_flags;
   logic             rsp_err;
   logic             busy;

`ifdef ALU_STATS_EN
   logic [15:0]      stat_ops;
   logic [15:0]      stat_errs;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_sel,
      output cmd_ready,
      output alu_a, alu_b, alu_select,
      input  alu_out, alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow,
      output rsp_valid, rsp_out, rsp_flags, rsp_err,
      input  rsp_ready,
      output busy, stat_ops, stat_errs
   );
   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_sel,
      input  cmd_ready,
      input  alu_a, alu_b, alu_select,
      output alu_out, alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow,
      input  rsp_valid, rsp_out, rsp_flags, rsp_err,
      output rsp_ready,
      input  busy, stat_ops, stat_errs
   );
`else
   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_sel,
      output cmd_ready,
      output alu_a, alu_b, alu_select,
      input  alu_out, alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow,
      output rsp_valid, rsp_out, rsp_flags, rsp_err,
      input  rsp_ready,
      output busy
   );
   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_sel,
      input  cmd_ready,
      input  alu_a, alu_b, alu_select,
      output alu_out, alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow,
      input  rsp_valid, rsp_out, rsp_flags, rsp_err,
      output rsp_ready,
      input  busy
   );
`endif
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues operands, captures result/flags, traps divide-by-zero; ALU_STATS_EN adds counters.
// Push->rsp_valid SETTLE+2 edges (trap 2), one op per SETTLE+3 cycles; cmd_ready=not full, response held until rsp_ready.
module alu_cmd_sequencer #(
   parameter int WIDTH      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE     = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   alu_cmd_sequencer_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       sel;
   } cmd_t;

   cmd_t             fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic [1:0]       state_q, state_d;
   logic             arm_q, arm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]       alu_sel_q, alu_sel_d;
   logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
   logic [4:0]       rsp_flags_q, rsp_flags_d;
   logic             push, pop, div_zero;
   cmd_t             head;

   assign bus.cmd_ready = (count_q != FULL_CNT);
   assign push          = bus.cmd_valid & bus.cmd_ready;
   // Dispatch only after the FIFO has been seen non-empty for a full IDLE cycle.
   assign pop           = (state_q == IDLE) & arm_q;
   assign head          = fifo_q[rd_ptr_q];
   assign div_zero      = (head.sel == 2'b11) && (head.b == '0);
   assign arm_d         = (state_q == IDLE) && (count_q != '0) && !pop;

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_out_d   = rsp_out_q;
      rsp_flags_d = rsp_flags_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               if (div_zero) begin
                  rsp_out_d   = '1;
                  rsp_flags_d = '0;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  alu_a_d   = head.a;
                  alu_b_d   = head.b;
                  alu_sel_d = head.sel;
                  cnt_d     = CNT_W'(SETTLE - 1);
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rsp_out_d   = bus.alu_out;
               rsp_flags_d = {bus.alu_overflow, bus.alu_parity, bus.alu_sign,
                              bus.alu_carry, bus.alu_zero};
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         arm_q       <= 1'b0;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_out_q   <= '0;
         rsp_flags_q <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q     <= count_d;
         state_q     <= state_d;
         arm_q       <= arm_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_out_q   <= rsp_out_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

`ifdef ALU_STATS_EN
   logic [15:0] stat_ops_q, stat_ops_d, stat_errs_q, stat_errs_d;
   logic        rsp_hs;

   assign rsp_hs = rsp_valid_q & bus.rsp_ready;

   always_comb begin
      stat_ops_d  = stat_ops_q;
      stat_errs_d = stat_errs_q;
      if (rsp_hs) begin
         if (stat_ops_q != 16'hFFFF)
            stat_ops_d = stat_ops_q + 16'd1;
         if (rsp_err_q && (stat_errs_q != 16'hFFFF))
            stat_errs_d = stat_errs_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_ops_q  <= '0;
         stat_errs_q <= '0;
      end else begin
         stat_ops_q  <= stat_ops_d;
         stat_errs_q <= stat_errs_d;
      end
   end

   assign bus.stat_ops  = stat_ops_q;
   assign bus.stat_errs = stat_errs_q;
`endif

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_select = alu_sel_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.rsp_out    = rsp_out_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.busy       = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural 4-bit ALU plus an in-order response queue model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_cmd_sequencer #(.WIDTH(WIDTH), .FIFO_DEPTH(4), .SETTLE(1)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   // Returns {overflow, parity, sign, carry, zero, result}.
   function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
      logic [7:0] w;
      logic [3:0] r;
      logic       c, v;
      w = 8'd0; c = 1'b0; v = 1'b0;
      case (sel)
         2'b00:   begin w = {4'd0, a} + {4'd0, b}; c = w[4]; end
         2'b01:   begin w = {4'd0, a} - {4'd0, b}; c = (a < b); end
         2'b10:   begin w = {4'd0, a} * {4'd0, b}; c = |w[7:4]; end
         default: w = (b == 4'd0) ? 8'd0 : {4'd0, a / b};
      endcase
      r = w[3:0];
      if (sel == 2'b00) v = (a[3] == b[3]) && (r[3] != a[3]);
      if (sel == 2'b01) v = (a[3] != b[3]) && (r[3] != a[3]);
      if (sel == 2'b10) v = c;
      return {v, ~^r, r[3], c, (r == 4'd0), r};
   endfunction

   // Expected response {err, flags, out} for a command.
   function automatic logic [9:0] exp_rsp(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
      if (sel == 2'b11 && b == 4'd0)
         return {1'b1, 5'd0, 4'hF};
      return {1'b0, alu_fn(a, b, sel)};
   endfunction

   logic [8:0] alu_res;
   assign alu_res      = alu_fn(bus.alu_a, bus.alu_b, bus.alu_select);
   assign bus.alu_out  = alu_res[3:0];
   assign {bus.alu_overflow, bus.alu_parity, bus.alu_sign, bus.alu_carry, bus.alu_zero} = alu_res[8:4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
      bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = sel; bus.cmd_valid = 1'b1;
   endtask

   task automatic do_reset();
      bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
      bus.rsp_ready = 1'b0;
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((bus.busy || bus.rsp_valid) && n < 60) begin tick(); n++; end
      checks++;
      if (bus.busy || bus.rsp_valid)
         $display("FAIL %s_idle: busy=%b rsp_valid=%b, want 0 0", name, bus.busy, bus.rsp_valid);
      else passes++;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
      reset_n = 1'b0;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.busy, bus.cmd_ready} !== 4'b0001)
         $display("FAIL reset_ctl: {valid,err,busy,ready}=%b want 0001",
                  {bus.rsp_valid, bus.rsp_err, bus.busy, bus.cmd_ready});
      else passes++;
      checks++;
      if ({bus.rsp_out, bus.rsp_flags} !== 9'd0)
         $display("FAIL reset_rsp: out=%h flags=%b want 0 0", bus.rsp_out, bus.rsp_flags);
      else passes++;
      checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_select} !== 10'd0)
         $display("FAIL reset_alu: a=%h b=%h sel=%b want 0", bus.alu_a, bus.alu_b, bus.alu_select);
      else passes++;
      reset_n = 1'b1;
      tick(); tick();
      checks++;
      if ({bus.rsp_valid, bus.busy, bus.cmd_ready} !== 3'b001)
         $display("FAIL reset_idle: {valid,busy,ready}=%b want 001", {bus.rsp_valid, bus.busy, bus.cmd_ready});
      else passes++;
   endtask

   task automatic test_add();
      int cyc;
      bus.rsp_ready = 1'b1;
      drive(4'd7, 4'd9, 2'b00);
      tick();
      bus.cmd_valid = 1'b0;
      cyc = 0;
      while (!bus.rsp_valid && cyc < 10) begin tick(); cyc++; end
      checks++;
      if (cyc != 3) $display("FAIL add_latency: rsp_valid after %0d edges, want 3", cyc);
      else passes++;
      checks++;
      if ({bus.rsp_err, bus.rsp_flags, bus.rsp_out} !== {1'b0, 5'b01011, 4'h0})
         $display("FAIL add_rsp: err=%b flags=%b out=%h want 0 01011 0", bus.rsp_err, bus.rsp_flags, bus.rsp_out);
      else passes++;
      wait_idle("add");
   endtask

   task automatic test_sub();
      drive(4'd3, 4'd2, 2'b01);
      tick();
      bus.cmd_valid = 1'b0;
      tick(); tick();
      checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_select, bus.rsp_valid} !== {4'd3, 4'd2, 2'b01, 1'b0})
         $display("FAIL sub_wait: a=%h b=%h sel=%b valid=%b want 3 2 01 0",
                  bus.alu_a, bus.alu_b, bus.alu_select, bus.rsp_valid);
      else passes++;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_flags, bus.rsp_out} !== {1'b1, exp_rsp(4'd3, 4'd2, 2'b01)} ||
          bus.rsp_out !== 4'd1)
         $display("FAIL sub_rsp: valid=%b err=%b flags=%b out=%h want 1 0 00000 1",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_flags, bus.rsp_out);
      else passes++;
      wait_idle("sub");
   endtask

   task automatic test_div_zero();
      drive(4'd9, 4'd0, 2'b11);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0) $display("FAIL div0_early: rsp_valid=%b at E+1, want 0", bus.rsp_valid);
      else passes++;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_out, bus.rsp_flags} !== {1'b1, 1'b1, 4'hF, 5'd0})
         $display("FAIL div0_rsp: valid=%b err=%b out=%h flags=%b want 1 1 f 00000",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_out, bus.rsp_flags);
      else passes++;
      checks++;
      if ({bus.alu_a, bus.alu_b, bus.alu_select} !== {4'd3, 4'd2, 2'b01})
         $display("FAIL div0_alu: a=%h b=%h sel=%b want 3 2 01", bus.alu_a, bus.alu_b, bus.alu_select);
      else passes++;
      wait_idle("div0");
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp_q[$];
      logic [3:0] a, b;
      logic [1:0] s;
      int         n, got, last_hs;
      logic       pushed6;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = 4'($urandom); b = 4'($urandom); s = 2'($urandom);
         drive(a, b, s);
         @(negedge clk);
         checks++;
         if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready_%0d: cmd_ready=%b want 1", i, bus.cmd_ready);
         else passes++;
         exp_q.push_back(exp_rsp(a, b, s));
         tick();
      end
      a = 4'($urandom); b = 4'($urandom); s = 2'($urandom);
      drive(a, b, s);
      exp_q.push_back(exp_rsp(a, b, s));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
             {bus.rsp_err, bus.rsp_flags, bus.rsp_out} !== exp_q[0])
            $display("FAIL b2b_hold_%0d: ready=%b valid=%b rsp=%h want 0 1 %h", i, bus.cmd_ready,
                     bus.rsp_valid, {bus.rsp_err, bus.rsp_flags, bus.rsp_out}, exp_q[0]);
         else passes++;
         tick();
      end
      bus.rsp_ready = 1'b1;
      got = 0; n = 0; last_hs = 0; pushed6 = 1'b0;
      while (got < 6 && n < 60) begin
         @(negedge clk);
         if (bus.cmd_valid && bus.cmd_ready) pushed6 = 1'b1;
         if (bus.rsp_valid) begin
            checks++;
            if ({bus.rsp_err, bus.rsp_flags, bus.rsp_out} !== exp_q[0])
               $display("FAIL b2b_order_%0d: rsp=%h want %h", got, {bus.rsp_err, bus.rsp_flags, bus.rsp_out}, exp_q[0]);
            else passes++;
            void'(exp_q.pop_front());
            if (got > 0) begin
               checks++;
               if (n - last_hs != 4) $display("FAIL b2b_rate_%0d: gap %0d cycles want 4", got, n - last_hs);
               else passes++;
            end
            last_hs = n;
            got++;
         end
         tick();
         if (pushed6) bus.cmd_valid = 1'b0;
         n++;
      end
      checks++;
      if (got != 6) $display("FAIL b2b_count: got %0d responses want 6", got);
      else passes++;
      bus.cmd_valid = 1'b0;
      wait_idle("b2b");
   endtask

   task automatic test_random();
      logic [9:0] exp_q[$];
      logic [9:0] held, obs;
      logic       was_stalled;
      int         n;
      was_stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.cmd_valid = ($urandom_range(99, 0) < 60);
         bus.cmd_a     = 4'($urandom);
         bus.cmd_b     = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom);
         bus.cmd_sel   = 2'($urandom);
         bus.rsp_ready = ($urandom_range(99, 0) < 65);
         @(negedge clk);
         obs = {bus.rsp_err, bus.rsp_flags, bus.rsp_out};
         if (was_stalled) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || obs !== held)
               $display("FAIL rand_stable_%0d: valid=%b rsp=%h want 1 %h", cyc, bus.rsp_valid, obs, held);
            else passes++;
         end
         if (bus.cmd_valid && bus.cmd_ready) exp_q.push_back(exp_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_sel));
         if (bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) $display("FAIL rand_extra_%0d: rsp=%h with none expected", cyc, obs);
            else if (obs !== exp_q[0]) $display("FAIL rand_rsp_%0d: rsp=%h want %h", cyc, obs, exp_q[0]);
            else passes++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         was_stalled = bus.rsp_valid && !bus.rsp_ready;
         held = obs;
         tick();
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            checks++;
            if ({bus.rsp_err, bus.rsp_flags, bus.rsp_out} !== exp_q[0])
               $display("FAIL rand_drain: rsp=%h want %h", {bus.rsp_err, bus.rsp_flags, bus.rsp_out}, exp_q[0]);
            else passes++;
            void'(exp_q.pop_front());
         end
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) $display("FAIL rand_lost: %0d responses missing, want 0", exp_q.size());
      else passes++;
      wait_idle("rand");
   endtask

   task automatic test_reset_mid();
      logic [3:0] ta [5];
      logic [3:0] tb [5];
      logic [1:0] ts [5];
      int         n, seen;
      ta = '{4'd1, 4'd5, 4'd2, 4'd3, 4'd4};
      tb = '{4'd1, 4'd6, 4'd2, 4'd1, 4'd4};
      ts = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(ta[i], tb[i], ts[i]);
         tick();
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      n = 0;
      while (bus.alu_select !== 2'b10 && n < 20) begin tick(); n++; end
      checks++;
      if (n >= 20 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL rstmid_wait: sel=%b valid=%b busy=%b want 10 0 1", bus.alu_select, bus.rsp_valid, bus.busy);
      else passes++;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.rsp_valid, bus.busy, bus.cmd_ready} !== 3'b001)
         $display("FAIL rstmid_async: {valid,busy,ready}=%b want 001", {bus.rsp_valid, bus.busy, bus.cmd_ready});
      else passes++;
      #2;
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      checks++;
      if (seen != 0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1)
         $display("FAIL rstmid_after: rsp cycles=%0d busy=%b ready=%b want 0 0 1", seen, bus.busy, bus.cmd_ready);
      else passes++;
   endtask

`ifdef ALU_STATS_EN
   task automatic test_stats();
      do_reset();
      checks++;
      if ({bus.stat_ops, bus.stat_errs} !== 32'd0)
         $display("FAIL stats_reset: ops=%0d errs=%0d want 0 0", bus.stat_ops, bus.stat_errs);
      else passes++;
      bus.rsp_ready = 1'b1;
      drive(4'd2, 4'd3, 2'b00); tick(); bus.cmd_valid = 1'b0; wait_idle("stats0");
      drive(4'd4, 4'd0, 2'b11); tick(); bus.cmd_valid = 1'b0; wait_idle("stats1");
      drive(4'd5, 4'd1, 2'b01); tick(); bus.cmd_valid = 1'b0; wait_idle("stats2");
      checks++;
      if (bus.stat_ops !== 16'd3 || bus.stat_errs !== 16'd1)
         $display("FAIL stats_count: ops=%0d errs=%0d want 3 1", bus.stat_ops, bus.stat_errs);
      else passes++;
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
      bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
      test_reset();
      test_add();
      test_sub();
      test_div_zero();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef ALU_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential front-end that feeds the 4-bit combinational ALU: accepts operation commands over a valid/ready interface, buffers them in a small FIFO, drives the ALU operand/select inputs, waits a settle window, then captures result and flags and returns them over a valid/ready response interface. It is the issuing side of the ALU operand/result interface. It traps divide-by-zero without issuing it to the ALU.

Parameters:
WIDTH, 4, operand/result width; must match the ALU.
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.
SETTLE, 1, cycles operands are held before capture; >=1.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals not-full
cmd_a  input  WIDTH  operand a
cmd_b  input  WIDTH  operand b
cmd_sel  input  2  00 add, 01 sub, 10 mul, 11 div
alu_a  output  WIDTH  registered operand a to ALU
alu_b  output  WIDTH  registered operand b to ALU
alu_select  output  2  registered select to ALU
alu_out  input  WIDTH  ALU result
alu_zero, alu_carry, alu_sign, alu_parity, alu_overflow  input  1 each  ALU flags
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_out  output  WIDTH  captured result
rsp_flags  output  5  {overflow, parity, sign, carry, zero}
rsp_err  output  1  divide-by-zero trap
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, reset_n low): FIFO emptied, state IDLE, alu_a/alu_b/alu_select=0, rsp_valid=0, rsp_out=0, rsp_flags=0, rsp_err=0, busy=0, cmd_ready=1. Reset mid-operation discards in-flight and queued commands; no response is produced for them.
- Push when cmd_valid & cmd_ready at a clock edge. No FIFO bypass: a command pushed into an empty FIFO is poppable the following cycle. A push and pop in the same cycle leave the count unchanged.
- FSM states IDLE, WAIT, RESP.
- IDLE, FIFO non-empty: pop the head.
  - If sel=11 and b=0: do not update alu_*; load rsp_out=all ones, rsp_flags=0, rsp_err=1, rsp_valid=1; go to RESP.
  - Otherwise: register alu_a/alu_b/alu_select, load counter=SETTLE-1, go to WAIT.
- WAIT: counter>0 decrements. At counter=0, capture alu_out and the flags into rsp_out/rsp_flags, set rsp_err=0, rsp_valid=1, go to RESP.
- RESP: hold all rsp_* stable until rsp_valid & rsp_ready; then rsp_valid=0 and go to IDLE. The next pop occurs no earlier than the following cycle.
- alu_* retain their last issued values between operations.
- Latency: push at edge E gives rsp_valid high after edge E+2+SETTLE (normal op) or E+2 (div-by-zero trap). Throughput is one op per SETTLE+3 cycles with rsp_ready held high.
- Full: cmd_ready=0 when count=FIFO_DEPTH; cmd_valid is ignored. Empty: IDLE stays idle. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
ALU_STATS_EN. When defined, adds outputs stat_ops (16-bit, increments on every response handshake) and stat_errs (16-bit, increments on handshakes with rsp_err=1). Both saturate at 0xFFFF and reset to 0. When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push add a=7 b=9 with rsp_ready=1 -> rsp_valid after edge E+3; rsp_out=0, rsp_flags=5'b01011 (parity=1, carry=1, zero=1; overflow=0, sign=0); rsp_err=0.
- Push sub a=3 b=2 -> alu_select=01 during WAIT; rsp_out=1, zero=0, sign=0.
- Push div a=9 b=0 -> alu_* unchanged from previous op; rsp_out=4'hF, rsp_flags=0, rsp_err=1 after edge E+2.
- rsp_ready=0, push 6 back-to-back commands -> 1 popped plus 4 queued; cmd_ready falls after the 5th push; 6th held. Release rsp_ready -> responses return in order, each held stable until its handshake.
- Assert reset_n=0 during WAIT with 3 queued -> immediately rsp_valid=0, busy=0, cmd_ready=1; no responses after release.
- With ALU_STATS_EN, run 3 ops including 1 div-by-zero -> stat_ops=3, stat_errs=1.
